// File: rtl/corefft_axi4s_pkg.sv
// Shared definitions for the CoreFFT AXI4-Stream source and the FFT-side wrapper:
// FSM encoding, config-beat bit map and a constant width helper.
package corefft_axi4s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CFG    = 2'd1,
        ST_STREAM = 2'd2
    } fsm_state_t;

    localparam int CFG_INV_BIT     = 0;
    localparam int CFG_REFRESH_BIT = 1;

    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/corefft_sfifo_fwft.sv
// Single-clock first-word-fall-through FIFO: RD_DATA shows the head whenever !EMPTY.
// A write while full is taken only if a read retires the head in the same cycle.
module corefft_sfifo_fwft
    import corefft_axi4s_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        WR_EN,
    input  logic [WIDTH-1:0]            WR_DATA,
    input  logic                        RD_EN,
    output logic [WIDTH-1:0]            RD_DATA,
    output logic                        FULL,
    output logic                        EMPTY,
    output logic [ceil_log2(DEPTH):0]   COUNT
);

    localparam int AW = ceil_log2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign pop     = RD_EN & ~EMPTY;
    assign push    = WR_EN & (~FULL | pop);
    assign FULL    = (COUNT == (AW+1)'(DEPTH));
    assign EMPTY   = (COUNT == '0);
    assign RD_DATA = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            COUNT <= COUNT + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= WR_DATA;
    end

endmodule

// File: rtl/corefft_axi4s_frame_source.sv
// AXI4-Stream master feeding FFT frames: buffers native complex samples, marks every
// FFT_SIZE-th beat with TLAST and inserts config beats only between frames.
module corefft_axi4s_frame_source
    import corefft_axi4s_pkg::*;
#(
    parameter int DATA_BITS     = 18,
    parameter int AXI4S_IN_DATA = 24,
    parameter int FFT_SIZE      = 256,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              ENABLE,
    input  logic [DATA_BITS-1:0]              SAMP_RE,
    input  logic [DATA_BITS-1:0]              SAMP_IM,
    input  logic                              SAMP_VALID,
    input  logic                              CFG_REQ,
    input  logic                              CFG_INVERSE,
    input  logic                              CFG_REFRESH,
    output logic                              M_DATAI_TVALID,
    input  logic                              M_DATAI_TREADY,
    output logic [2*AXI4S_IN_DATA-1:0]        M_TDATAI,
    output logic                              M_TLASTI,
    output logic                              M_CONFIGI_TVALID,
    input  logic                              M_CONFIGI_TREADY,
    output logic [7:0]                        M_CONFIGI,
    output logic                              OVERRUN,
    output logic [15:0]                       FRAMES_SENT,
    output fsm_state_t                        DBG_STATE,
    output logic [ceil_log2(FIFO_DEPTH):0]    DBG_FIFO_COUNT
);

    localparam int                CNT_W     = ceil_log2(FFT_SIZE);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(FFT_SIZE - 1);

    fsm_state_t               state;
    fsm_state_t               state_nxt;
    logic [CNT_W-1:0]         beat_cnt;
    logic                     beat_last;
    logic                     cfg_pend;
    logic [7:0]               cfg_word;
    logic [7:0]               cfg_req_word;
    logic [7:0]               cfg_beat;
    logic                     load_cfg;
    logic                     data_hs;
    logic                     cfg_hs;
    logic [2*DATA_BITS-1:0]   fifo_dout;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic signed [DATA_BITS-1:0] head_re;
    logic signed [DATA_BITS-1:0] head_im;

    corefft_sfifo_fwft #(
        .WIDTH (2*DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .WR_EN   (SAMP_VALID),
        .WR_DATA ({SAMP_IM, SAMP_RE}),
        .RD_EN   (data_hs),
        .RD_DATA (fifo_dout),
        .FULL    (fifo_full),
        .EMPTY   (fifo_empty),
        .COUNT   (DBG_FIFO_COUNT)
    );

    // Valid/ready: a beat transfers on a rising edge where TVALID & TREADY. TVALID is only
    // raised with stable payload (FIFO head / latched cfg_beat) and only falls on transfer or RST.
    assign M_DATAI_TVALID   = (state == ST_STREAM) & ~fifo_empty;
    assign beat_last        = (beat_cnt == LAST_BEAT);
    assign M_TLASTI         = M_DATAI_TVALID & beat_last;
    assign data_hs          = M_DATAI_TVALID & M_DATAI_TREADY;
    assign M_CONFIGI_TVALID = (state == ST_CFG);
    assign cfg_hs           = M_CONFIGI_TVALID & M_CONFIGI_TREADY;
    assign M_CONFIGI        = cfg_beat;
    assign DBG_STATE        = state;

    assign head_re  = fifo_dout[DATA_BITS-1:0];
    assign head_im  = fifo_dout[2*DATA_BITS-1:DATA_BITS];
    assign M_TDATAI = M_DATAI_TVALID ?
                      {AXI4S_IN_DATA'(head_im), AXI4S_IN_DATA'(head_re)} : '0;

    always_comb begin
        cfg_req_word                  = '0;
        cfg_req_word[CFG_INV_BIT]     = CFG_INVERSE;
        cfg_req_word[CFG_REFRESH_BIT] = CFG_REFRESH;
    end

    always_comb begin
        state_nxt = state;
        load_cfg  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_pend) begin
                    state_nxt = ST_CFG;
                    load_cfg  = 1'b1;
                end else if (ENABLE && !fifo_empty) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_CFG:    if (cfg_hs) state_nxt = ST_IDLE;
            ST_STREAM: if (data_hs && beat_last) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // The pending request is copied into cfg_beat on entering CFG, so a later CFG_REQ
    // only queues another beat and never disturbs the one already on the bus.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            cfg_pend    <= 1'b0;
            cfg_word    <= '0;
            cfg_beat    <= '0;
            OVERRUN     <= 1'b0;
            FRAMES_SENT <= '0;
        end else begin
            state <= state_nxt;
            if (data_hs) beat_cnt <= beat_cnt + CNT_W'(1);
            if (data_hs && beat_last) FRAMES_SENT <= FRAMES_SENT + 16'd1;
            if (load_cfg) cfg_beat <= cfg_word;
            if (CFG_REQ) begin
                cfg_pend <= 1'b1;
                cfg_word <= cfg_req_word;
            end else if (load_cfg) begin
                cfg_pend <= 1'b0;
            end
            if (SAMP_VALID && fifo_full && !data_hs) OVERRUN <= 1'b1;
        end
    end

endmodule
